// File: rtl/calc_cmd_sched.sv
// calc_cmd_sched: schedules keypad codes into the calc datapath and collects
// its serialized digit output into a parallel display bank.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   key_valid/_code  key code offered by the keypad front-end
//   key_ready        FIFO can take a key (not full, not in error)
//   fifo_count       number of buffered key codes
//   calc_cmd         registered command to calc (IDLE_CMD when nothing issued)
//   calc_status      calc state: 00 error, 01 busy, 10 ready, 11 printing
//   calc_data/_pos   serialized digit stream from calc (pos 1..8 valid)
//   disp_digits      8-digit display bank, nibble i = digit i
//   disp_valid       one-cycle pulse when a capture completes
//   err              sticky error flag, cleared only by reset
module calc_cmd_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [3:0]  IDLE_CMD   = 4'b1101,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    output logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [3:0]                    calc_cmd,
    input  logic [1:0]                    calc_status,
    input  logic [3:0]                    calc_data,
    input  logic [3:0]                    calc_pos,
    output logic [31:0]                   disp_digits,
    output logic                          disp_valid,
    output logic                          err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_ERROR   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]        calc_cmd_q, calc_cmd_d;
    logic [31:0]       disp_q, disp_d;
    logic              disp_valid_q, disp_valid_d;
    logic              err_q, err_d;

    logic [3:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic full, empty, push, pop, flush, cap_en;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign key_ready = !full && (state_q != S_ERROR);
    assign push      = key_valid && key_ready;
    // ISSUE is only entered with a non-empty FIFO, so the pop is always legal
    assign pop       = (state_q == S_ISSUE);
    assign flush     = (state_d == S_ERROR);

    // Key-code storage; entries beyond the pointers are don't-care
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= key_code;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            to_cnt_q     <= '0;
            calc_cmd_q   <= IDLE_CMD;
            disp_q       <= '0;
            disp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            calc_cmd_q   <= calc_cmd_d;
            disp_q       <= disp_d;
            disp_valid_q <= disp_valid_d;
            err_q        <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        calc_cmd_d   = IDLE_CMD;
        disp_d       = disp_q;
        disp_valid_d = 1'b0;
        cap_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (calc_status == ST_ERR) begin
                    state_d = S_ERROR;
                end else if (!empty && (calc_status == ST_READY)) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                calc_cmd_d = fifo_mem[rd_ptr_q];
                to_cnt_d   = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                case (calc_status)
                    ST_PRINT: begin
                        // first printed digit arrives with the status change
                        cap_en  = 1'b1;
                        state_d = S_CAPTURE;
                    end
                    ST_BUSY: begin
                        to_cnt_d = to_cnt_q;
                    end
                    ST_ERR: begin
                        state_d = S_ERROR;
                    end
                    default: begin
                        if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                            state_d = S_IDLE;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
                        end
                    end
                endcase
            end
            S_CAPTURE: begin
                cap_en = 1'b1;
                if (calc_status == ST_READY) begin
                    disp_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (calc_status == ST_ERR) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // pos k carries digit k-1; pos 0 and pos > 8 write nothing
        if (cap_en) begin
            for (int i = 0; i < 8; i++) begin
                if (calc_pos == 4'(i + 1)) begin
                    disp_d[i*4 +: 4] = calc_data;
                end
            end
        end

        err_d = err_q | (state_d == S_ERROR);
    end

    assign fifo_count  = count_q;
    assign calc_cmd    = calc_cmd_q;
    assign disp_digits = disp_q;
    assign disp_valid  = disp_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_calc_cmd_sched.sv
// Directed bench for calc_cmd_sched: a vector table of single-key captures
// plus hand-written sequences for FIFO-full, timeout, busy, error and reset.
module tb_calc_cmd_sched;

    localparam logic [3:0] IDLE = 4'b1101;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [2:0]  fifo_count;
    logic [3:0]  calc_cmd;
    logic [1:0]  calc_status;
    logic [3:0]  calc_data;
    logic [3:0]  calc_pos;
    logic [31:0] disp_digits;
    logic        disp_valid;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    calc_cmd_sched #(
        .FIFO_DEPTH (4),
        .IDLE_CMD   (4'b1101),
        .TIMEOUT    (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .fifo_count  (fifo_count),
        .calc_cmd    (calc_cmd),
        .calc_status (calc_status),
        .calc_data   (calc_data),
        .calc_pos    (calc_pos),
        .disp_digits (disp_digits),
        .disp_valid  (disp_valid),
        .err         (err)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  key;
        int          npos;
        logic        bad;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] seen [$];
        logic       prev;
        int         adj;
        int         found;
        logic       flag;
        logic [3:0] codes [4];

        vecs[0] = '{key: 4'h3, npos: 8, bad: 1'b0, data: 32'h00000003, exp: 32'h00000003};
        vecs[1] = '{key: 4'h7, npos: 8, bad: 1'b0, data: 32'h87654321, exp: 32'h87654321};
        vecs[2] = '{key: 4'h1, npos: 2, bad: 1'b0, data: 32'h00000012, exp: 32'h87654312};
        vecs[3] = '{key: 4'h9, npos: 0, bad: 1'b1, data: 32'h00000000, exp: 32'h87654312};
        vecs[4] = '{key: 4'hF, npos: 8, bad: 1'b0, data: 32'hFFFFFFFF, exp: 32'hFFFFFFFF};

        reset       = 1'b0;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        calc_status = 2'b10;
        calc_data   = 4'h0;
        calc_pos    = 4'h0;

        // reset values
        tick();
        tick();
        chk("rst_count", fifo_count, 0);
        chk("rst_cmd", calc_cmd, IDLE);
        chk("rst_disp", disp_digits, 0);
        chk("rst_valid", disp_valid, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        tick();
        chk("rst_key_ready", key_ready, 1);

        // single-key capture vectors
        for (int v = 0; v < 5; v++) begin
            push(vecs[v].key);
            tick();
            chk($sformatf("v%0d_cmd_e1", v), calc_cmd, IDLE);
            tick();
            chk($sformatf("v%0d_cmd_e2", v), calc_cmd, vecs[v].key);
            for (int k = 1; k <= 8; k++) begin
                calc_status = 2'b11;
                if (k <= vecs[v].npos) begin
                    calc_pos  = 4'(k);
                    calc_data = vecs[v].data[(k-1)*4 +: 4];
                end else if (vecs[v].bad) begin
                    calc_pos  = 4'(8 + k);
                    calc_data = 4'hA;
                end else begin
                    calc_pos  = 4'h0;
                    calc_data = 4'hA;
                end
                tick();
                if (k == 1) chk($sformatf("v%0d_cmd_width", v), calc_cmd, IDLE);
            end
            calc_status = 2'b10;
            calc_pos    = 4'h0;
            tick();
            chk($sformatf("v%0d_valid", v), disp_valid, 1);
            chk($sformatf("v%0d_digits", v), disp_digits, vecs[v].exp);
            tick();
            chk($sformatf("v%0d_valid_drop", v), disp_valid, 0);
        end

        // FIFO fill while calc prints, fifth key dropped, in-order drain
        codes[0] = 4'h2; codes[1] = 4'h5; codes[2] = 4'h8; codes[3] = 4'hE;
        calc_status = 2'b11;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1;
            key_code  = codes[i];
            tick();
        end
        key_valid = 1'b0;
        chk("full_count", fifo_count, 4);
        chk("full_key_ready", key_ready, 0);
        push(4'h6);
        chk("full_drop_count", fifo_count, 4);
        calc_status = 2'b10;
        prev = 1'b0;
        adj  = 0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (calc_cmd !== IDLE) begin
                seen.push_back(calc_cmd);
                if (prev) adj++;
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
        chk("drain_n", seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) chk($sformatf("drain_%0d", i), seen[i], codes[i]);
            else chk($sformatf("drain_%0d", i), 4'hx, codes[i]);
        end
        chk("drain_adjacent", adj, 0);
        chk("drain_count", fifo_count, 0);

        // operator with calc staying ready: timeout, plus push/pop in same cycle
        push(4'hA);
        tick();
        key_valid = 1'b1;
        key_code  = 4'h6;
        tick();
        key_valid = 1'b0;
        chk("op_pushpop_count", fifo_count, 1);
        chk("op_cmd", calc_cmd, 4'hA);
        found = -1;
        flag  = 1'b0;
        for (int c = 1; c <= 40 && found < 0; c++) begin
            tick();
            if (disp_valid) flag = 1'b1;
            if (calc_cmd === 4'h6) found = c;
        end
        chk("op_next_issue_delay", found, 18);
        chk("op_no_valid", flag, 0);
        repeat (20) tick();

        // '=' with a long busy phase, then capture of 12
        push(4'hE);
        tick();
        tick();
        chk("busy_cmd", calc_cmd, 4'hE);
        calc_status = 2'b01;
        flag = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (disp_valid || calc_cmd !== IDLE) flag = 1'b1;
        end
        chk("busy_quiet", flag, 0);
        for (int k = 1; k <= 8; k++) begin
            calc_status = 2'b11;
            calc_pos    = 4'(k);
            calc_data   = (k == 1) ? 4'h2 : (k == 2) ? 4'h1 : 4'h0;
            tick();
        end
        calc_status = 2'b10;
        calc_pos    = 4'h0;
        tick();
        chk("busy_valid", disp_valid, 1);
        chk("busy_digits", disp_digits, 32'h00000012);
        tick();
        chk("busy_valid_drop", disp_valid, 0);

        // error during WAIT with a key still queued
        push(4'h4);
        key_valid = 1'b1;
        key_code  = 4'h5;
        tick();
        key_valid = 1'b0;
        tick();
        chk("err_cmd", calc_cmd, 4'h4);
        chk("err_pre_count", fifo_count, 1);
        calc_status = 2'b00;
        tick();
        chk("err_set", err, 1);
        chk("err_key_ready", key_ready, 0);
        chk("err_count", fifo_count, 0);
        chk("err_cmd_idle", calc_cmd, IDLE);
        calc_status = 2'b10;
        key_valid   = 1'b1;
        key_code    = 4'h7;
        repeat (5) tick();
        key_valid = 1'b0;
        chk("err_sticky", err, 1);
        chk("err_push_refused", fifo_count, 0);
        chk("err_cmd_hold", calc_cmd, IDLE);
        reset = 1'b0;
        #1;
        chk("err_cleared_by_reset", err, 0);
        tick();
        reset = 1'b1;
        tick();

        // reset in the middle of a capture with two keys queued
        push(4'h3);
        tick();
        tick();
        calc_status = 2'b11;
        calc_pos    = 4'h1;
        calc_data   = 4'h7;
        key_valid   = 1'b1;
        key_code    = 4'h1;
        tick();
        key_code    = 4'h2;
        calc_pos    = 4'h2;
        tick();
        key_valid = 1'b0;
        chk("mid_count", fifo_count, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_cmd", calc_cmd, IDLE);
        chk("mid_rst_disp", disp_digits, 0);
        chk("mid_rst_valid", disp_valid, 0);
        chk("mid_rst_err", err, 0);
        calc_status = 2'b10;
        calc_pos    = 4'h0;
        tick();
        reset = 1'b1;
        flag  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (calc_cmd !== IDLE || disp_valid) flag = 1'b1;
        end
        chk("mid_no_stale_issue", flag, 0);
        chk("mid_key_ready", key_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
